lab4_issue_sequencer: RTL and testbench
=======================================

Name: lab4_issue_sequencer

Overview:
- Sequences the register-file/ALU datapath.
- Accepts encoded ALU instructions from a requester over a valid/ready handshake and buffers them in a small FIFO.
- Issues one instruction per cycle by driving the datapath's A1, A2, A3, opcode and WE3 from registers.
- Supports a hold input that pauses issue, and counts completed issues for software or bench observation.

Parameters:
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- CNT_W, 16, width of issued_count.

Ports:
- CLK  input  1  system clock; all state updates on rising edge.
- RST  input  1  synchronous, active-high reset.
- in_valid  input  1  requester presents an instruction.
- in_ready  output  1  FIFO can accept; equals !full, combinational from occupancy.
- in_instr  input  17  instruction: [16:15] opcode, [14:10] A3 (dest), [9:5] A1, [4:0] A2.
- hold  input  1  pause issue while high.
- A1  output  5  datapath read address 1, registered.
- A2  output  5  datapath read address 2, registered.
- A3  output  5  datapath write address, registered.
- opcode  output  2  ALU operation, registered.
- WE3  output  1  datapath write enable, registered; high exactly one cycle per issued instruction.
- busy  output  1  (occupancy != 0) || WE3.
- issued_count  output  CNT_W  number of issues since reset.

Behaviour:
- Reset (RST high at an edge):
  - Occupancy 0, read/write pointers 0, state IDLE.
  - WE3, A1, A2, A3, opcode and issued_count all 0.
  - Pushes in that cycle are ignored.
  - Asserting reset mid-operation discards all FIFO contents; WE3 is 0 in the following cycle.
- Push:
  - Occurs at an edge when in_valid && in_ready && !RST.
  - in_instr is written at the write pointer; the pointer wraps modulo DEPTH.
  - When full, in_ready=0 and the requester must hold in_valid and in_instr stable.
  - No full-bypass: a pop in the same cycle does not raise in_ready.
- State machine (registered):
  - IDLE -> RUN at the edge where occupancy becomes nonzero.
  - RUN -> PAUSE at any edge where hold=1.
  - PAUSE -> RUN at an edge where hold=0. There is no issue on that edge, so resuming costs one bubble.
  - RUN -> IDLE at the edge where the last entry is popped with no simultaneous push.
  - PAUSE with an empty FIFO stays PAUSE until hold=0, then goes to RUN, then to IDLE.
- Issue (pop):
  - Condition: state==RUN && hold==0 && occupancy!=0.
  - At that edge, A1/A2/A3/opcode are loaded from the head entry, WE3 is set to 1, the read pointer advances, and issued_count increments.
  - Otherwise WE3 is set to 0, and A1/A2/A3/opcode hold their last issued values.
- Latency and ordering:
  - A push at edge k gives the earliest issue at edge k+1 (WE3 high during cycle k+1..k+2).
  - The datapath writes the ALU result at edge k+2.
  - Back-to-back issues are allowed every cycle. The datapath reads combinationally, so a dependent instruction issued the next cycle sees the written value; no stall logic is required.
- Simultaneous push and pop:
  - Occupancy is unchanged; both pointers advance.
  - Ordering is strictly FIFO.
- issued_count wraps from 2^CNT_W-1 to 0 with no flag.
- hold:
  - Sampled only at edges.
  - Asserting hold does not cancel a WE3 pulse already launched.
  - Pushes continue while paused.
- Occupancy counter is log2(DEPTH)+1 bits; full is occupancy==DEPTH, empty is occupancy==0.

Test Plan:
- Reset then single push of {opcode=2'b00, A3=3, A1=1, A2=2} at edge k:
  - A1=1, A2=2, A3=3, WE3=1 for exactly one cycle after edge k+1.
  - issued_count=1, then busy=0.
- Push 5 instructions back-to-back with DEPTH=4 and hold=1:
  - in_ready=0 after the 4th.
  - After hold drops: one bubble, then 4 consecutive WE3 pulses in push order, then the 5th issues.
- Continuous streaming with in_valid=1 and hold=0 for 10 instructions:
  - One issue per cycle after the first.
  - Occupancy never exceeds 1.
  - issued_count=10.
- Toggle hold high for 3 cycles mid-stream:
  - No WE3 during hold or on the first edge after hold falls.
  - Order preserved; no instruction lost or duplicated.
- Assert RST for one cycle with 3 entries queued:
  - WE3=0 and issued_count=0 next cycle; busy=0.
  - Later pushes issue normally from pointer 0.
- Preload issued_count near wrap (CNT_W=4) by issuing 17 instructions:
  - issued_count reads 1.

Source files
------------

// File: rtl/lab4_issue_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : lab4_issue_sequencer
// Purpose  : FIFO-buffered instruction issue sequencer for the regfile/ALU path
// Revision : 1.0
// ============================================================================
module lab4_issue_sequencer #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [16:0]      in_instr,
    input  logic             hold,
    output logic [4:0]       A1,
    output logic [4:0]       A2,
    output logic [4:0]       A3,
    output logic [1:0]       opcode,
    output logic             WE3,
    output logic             busy,
    output logic [CNT_W-1:0] issued_count
);

    localparam int c_ADDR_W = $clog2(DEPTH);
    localparam logic [c_ADDR_W:0] c_FULL = (c_ADDR_W+1)'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2
    } state_t;

    state_t              r_state;
    logic [16:0]         r_mem [DEPTH];
    logic [c_ADDR_W-1:0] r_wptr;
    logic [c_ADDR_W-1:0] r_rptr;
    logic [c_ADDR_W:0]   r_occ;
    logic [4:0]          r_a1;
    logic [4:0]          r_a2;
    logic [4:0]          r_a3;
    logic [1:0]          r_op;
    logic                r_we3;
    logic [CNT_W-1:0]    r_cnt;

    logic                w_push;
    logic                w_pop;
    logic [c_ADDR_W:0]   w_occ_next;
    logic [16:0]         w_head;

    // No full-bypass: readiness depends only on the current occupancy.
    assign in_ready   = (r_occ != c_FULL);
    assign w_push     = in_valid && in_ready;
    assign w_pop      = (r_state == S_RUN) && !hold && (r_occ != '0);
    assign w_occ_next = r_occ + (c_ADDR_W+1)'(w_push) - (c_ADDR_W+1)'(w_pop);
    assign w_head     = r_mem[r_rptr];

    always_ff @(posedge CLK) begin
        if (!RST && w_push) begin
            r_mem[r_wptr] <= in_instr;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= S_IDLE;
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_occ   <= '0;
            r_a1    <= '0;
            r_a2    <= '0;
            r_a3    <= '0;
            r_op    <= '0;
            r_we3   <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_occ <= w_occ_next;
            if (w_push) begin
                r_wptr <= r_wptr + c_ADDR_W'(1);
            end
            if (w_pop) begin
                r_op   <= w_head[16:15];
                r_a3   <= w_head[14:10];
                r_a1   <= w_head[9:5];
                r_a2   <= w_head[4:0];
                r_we3  <= 1'b1;
                r_rptr <= r_rptr + c_ADDR_W'(1);
                r_cnt  <= r_cnt + CNT_W'(1);
            end else begin
                r_we3  <= 1'b0;
            end

            case (r_state)
                S_IDLE: begin
                    if (w_occ_next != '0) r_state <= S_RUN;
                end
                S_RUN: begin
                    if (hold)                    r_state <= S_PAUSE;
                    else if (w_occ_next == '0)   r_state <= S_IDLE;
                end
                S_PAUSE: begin
                    // Resuming takes one edge with no issue.
                    if (!hold) r_state <= S_RUN;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign A1           = r_a1;
    assign A2           = r_a2;
    assign A3           = r_a3;
    assign opcode       = r_op;
    assign WE3          = r_we3;
    assign issued_count = r_cnt;
    assign busy         = (r_occ != '0) || r_we3;

endmodule
`default_nettype wire

// File: tb/tb_lab4_issue_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_lab4_issue_sequencer
// Purpose  : Self-checking bench: queue-based reference model plus directed pins
// Revision : 1.0
// ============================================================================
module tb_lab4_issue_sequencer;

    localparam int DEPTH = 4;
    localparam int CNT_W = 4;

    logic             CLK;
    logic             RST;
    logic             in_valid;
    logic             in_ready;
    logic [16:0]      in_instr;
    logic             hold;
    logic [4:0]       A1;
    logic [4:0]       A2;
    logic [4:0]       A3;
    logic [1:0]       opcode;
    logic             WE3;
    logic             busy;
    logic [CNT_W-1:0] issued_count;

    lab4_issue_sequencer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .CLK          (CLK),
        .RST          (RST),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_instr     (in_instr),
        .hold         (hold),
        .A1           (A1),
        .A2           (A2),
        .A3           (A3),
        .opcode       (opcode),
        .WE3          (WE3),
        .busy         (busy),
        .issued_count (issued_count)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [16:0] mk(input int op, input int a3, input int a1, input int a2);
        mk = {op[1:0], a3[4:0], a1[4:0], a2[4:0]};
    endfunction

    // Reference model: the FIFO is a queue; "active" means the sequencer has
    // work in flight, "paused" means hold stopped it and a resume bubble is due.
    logic [16:0] m_q[$];
    bit          m_started = 0;
    bit          m_active  = 0;
    bit          m_paused  = 0;
    bit          m_we      = 0;
    int          m_a1 = 0, m_a2 = 0, m_a3 = 0, m_op = 0, m_cnt = 0;

    always @(posedge CLK) begin
        bit          iss;
        bit          psh;
        logic [16:0] x;
        if (RST) begin
            m_q.delete();
            m_started = 1;
            m_active  = 0;
            m_paused  = 0;
            m_we      = 0;
            m_a1 = 0; m_a2 = 0; m_a3 = 0; m_op = 0; m_cnt = 0;
        end else begin
            iss = m_active && !m_paused && !hold && (m_q.size() != 0);
            psh = in_valid && (m_q.size() < DEPTH);
            if (iss) begin
                x     = m_q.pop_front();
                m_op  = int'(x[16:15]);
                m_a3  = int'(x[14:10]);
                m_a1  = int'(x[9:5]);
                m_a2  = int'(x[4:0]);
                m_we  = 1;
                m_cnt = (m_cnt + 1) % (1 << CNT_W);
            end else begin
                m_we = 0;
            end
            if (psh) m_q.push_back(in_instr);
            if (!m_active)      m_active = (m_q.size() != 0);
            else if (m_paused)  begin if (!hold) m_paused = 0; end
            else if (hold)      m_paused = 1;
            else if (m_q.size() == 0) m_active = 0;
        end
    end

    always @(negedge CLK) begin
        if (m_started) begin
            chk("we3",      32'(WE3),          32'(m_we));
            chk("a1",       32'(A1),           32'(m_a1));
            chk("a2",       32'(A2),           32'(m_a2));
            chk("a3",       32'(A3),           32'(m_a3));
            chk("opcode",   32'(opcode),       32'(m_op));
            chk("count",    32'(issued_count), 32'(m_cnt));
            chk("in_ready", 32'(in_ready),     32'(m_q.size() < DEPTH));
            chk("busy",     32'(busy),         32'((m_q.size() != 0) || m_we));
        end
    end

    // One clock: drive inputs, report whether a push is accepted, return at negedge.
    task automatic cyc(input logic r, input logic v, input logic [16:0] ins,
                       input logic h, output bit acc);
        RST = r; in_valid = v; in_instr = ins; hold = h;
        #1;
        acc = !r && v && in_ready;
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic do_reset();
        bit a;
        cyc(1'b1, 1'b0, 17'd0, 1'b0, a);
        cyc(1'b0, 1'b0, 17'd0, 1'b0, a);
    endtask

    task automatic stream(input int n, input int base);
        bit a;
        int sent = 0;
        int guard = 0;
        while (sent < n && guard < 200) begin
            cyc(1'b0, 1'b1, mk(sent % 4, base + sent, sent, sent + 1), 1'b0, a);
            if (a) sent++;
            guard++;
        end
        if (sent < n) chk("stream_timeout", 32'(sent), 32'(n));
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 17'd0, 1'b0, a);
    endtask

    initial begin
        bit       a;
        bit       pushed5;
        bit       we_seen[8];
        int       a3_seen[8];
        bit       ready_ok;
        RST = 1'b1; in_valid = 1'b0; in_instr = '0; hold = 1'b0;

        // Reset state, then a single instruction.
        do_reset();
        chk("rst_we3",   32'(WE3), 0);
        chk("rst_count", 32'(issued_count), 0);
        chk("rst_ready", 32'(in_ready), 1);
        chk("rst_busy",  32'(busy), 0);
        cyc(1'b0, 1'b1, mk(0, 3, 1, 2), 1'b0, a);
        cyc(1'b0, 1'b0, 17'd0, 1'b0, a);
        chk("single_we3", 32'(WE3), 1);
        chk("single_a1",  32'(A1), 1);
        chk("single_a2",  32'(A2), 2);
        chk("single_a3",  32'(A3), 3);
        cyc(1'b0, 1'b0, 17'd0, 1'b0, a);
        chk("single_we3_off", 32'(WE3), 0);
        chk("single_count",   32'(issued_count), 1);
        chk("single_busy",    32'(busy), 0);

        // Fill under hold, overflow attempt, then release.
        do_reset();
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, mk(1, 11 + i, i, i), 1'b1, a);
        chk("full_ready", 32'(in_ready), 0);
        cyc(1'b0, 1'b1, mk(1, 15, 4, 4), 1'b1, a);
        chk("full_reject", 32'(a), 0);
        pushed5 = 0;
        for (int j = 0; j < 8; j++) begin
            cyc(1'b0, !pushed5, mk(1, 15, 4, 4), 1'b0, a);
            if (a) pushed5 = 1;
            we_seen[j] = WE3;
            a3_seen[j] = int'(A3);
        end
        chk("resume_bubble", 32'(we_seen[0]), 0);
        for (int j = 1; j <= 5; j++) begin
            chk("resume_we3", 32'(we_seen[j]), 1);
            chk("resume_order", 32'(a3_seen[j]), 32'(10 + j));
        end
        chk("resume_done", 32'(we_seen[6]), 0);

        // Streaming: pushes every cycle, FIFO never fills.
        do_reset();
        ready_ok = 1;
        fork
            begin
                for (int i = 0; i < 16; i++) begin
                    @(negedge CLK);
                    if (!in_ready) ready_ok = 0;
                end
            end
            stream(10, 1);
        join
        chk("stream_ready", 32'(ready_ok), 1);
        chk("stream_count", 32'(issued_count), 10);

        // Reset with queued entries discards them.
        do_reset();
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, mk(3, 20 + i, 1, 1), 1'b1, a);
        cyc(1'b1, 1'b1, mk(3, 30, 1, 1), 1'b0, a);
        chk("midrst_we3",   32'(WE3), 0);
        chk("midrst_count", 32'(issued_count), 0);
        chk("midrst_busy",  32'(busy), 0);
        cyc(1'b0, 1'b1, mk(2, 7, 8, 9), 1'b0, a);
        cyc(1'b0, 1'b0, 17'd0, 1'b0, a);
        chk("midrst_we3_new", 32'(WE3), 1);
        chk("midrst_a3_new",  32'(A3), 7);
        chk("midrst_op_new",  32'(opcode), 2);

        // Counter wrap with a 4-bit count.
        do_reset();
        stream(17, 2);
        chk("wrap_count", 32'(issued_count), 1);

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            logic        r;
            logic        v;
            logic [16:0] ins;
            r = ($urandom_range(0, 149) == 0);
            if (in_valid && !in_ready && !RST) begin
                v   = in_valid;
                ins = in_instr;
            end else begin
                v   = ($urandom_range(0, 2) != 0);
                ins = 17'($urandom);
            end
            cyc(r, v, ins, ($urandom_range(0, 4) == 0), a);
        end

        cyc(1'b0, 1'b0, 17'd0, 1'b0, a);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
